// File: rtl/coin_pkg.sv
// Shared definitions for the coin charger session controller: state encoding,
// key event classes and datapath widths.
package coin_pkg;

  localparam int unsigned AMT_W = 7;
  localparam int unsigned REM_W = 12;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned DCNT_W = 2;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ENTER  = 4'b0010;
  localparam logic [3:0] ST_CHARGE = 4'b0100;
  localparam logic [3:0] ST_DONE   = 4'b1000;

  localparam logic [KEY_W-1:0] KEY_NONE = 4'b1111;

  typedef enum logic [2:0] {
    EVT_NULL,
    EVT_DIGIT,
    EVT_START,
    EVT_OK,
    EVT_RESET
  } evt_class_e;

  // Priority: reset > ok > start > digit; anything else is a null event.
  function automatic evt_class_e classify(input logic k_reset, input logic k_ok,
                                          input logic k_start,
                                          input logic [KEY_W-1:0] k_data);
    if (k_reset) return EVT_RESET;
    if (k_ok) return EVT_OK;
    if (k_start) return EVT_START;
    if ((k_data != KEY_NONE) && (k_data <= KEY_W'(9))) return EVT_DIGIT;
    return EVT_NULL;
  endfunction

endpackage

// File: rtl/charge_controller_key_event.sv
// Turns the keypad scanner's idle falling edge into one event per press,
// classified from the scanner outputs one cycle after the edge.
module key_event
  import coin_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             kb_idle,
  input  logic [KEY_W-1:0] kb_data,
  input  logic             kb_start,
  input  logic             kb_reset,
  input  logic             kb_ok,
  output logic             evt,
  output evt_class_e       evt_class,
  output logic [KEY_W-1:0] evt_digit
);

  logic r_idle_d;
  logic r_live;
  logic r_evt;
  logic w_fall;

  // r_live masks the first compare after reset so a key held through reset
  // is treated as already seen rather than as a fresh press.
  assign w_fall = r_live & r_idle_d & ~kb_idle;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idle_d <= 1'b1;
      r_live   <= 1'b0;
      r_evt    <= 1'b0;
    end else begin
      r_idle_d <= kb_idle;
      r_live   <= 1'b1;
      r_evt    <= w_fall;
    end
  end

  assign evt       = r_evt;
  assign evt_class = classify(kb_reset, kb_ok, kb_start, kb_data);
  assign evt_digit = kb_data;

endmodule

// File: rtl/charge_controller.sv
// Charging session sequencer: arm, amount entry, validation, 1 Hz countdown
// and completion hold, driving display fields and the charger enable.
module charge_controller
  import coin_pkg::*;
#(
  parameter int unsigned MAX_AMOUNT   = 20,
  parameter int unsigned SEC_PER_UNIT = 30,
  parameter int unsigned TIMEOUT_S    = 10,
  parameter int unsigned DONE_S       = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tick_1hz,
  input  logic              kb_idle,
  input  logic [KEY_W-1:0]  kb_data,
  input  logic              kb_start,
  input  logic              kb_reset,
  input  logic              kb_ok,
  output logic              charging,
  output logic              done,
  output logic              err,
  output logic [AMT_W-1:0]  amount,
  output logic [DCNT_W-1:0] digit_cnt,
  output logic [REM_W-1:0]  remaining
);

  localparam int unsigned TMR_MAX = (TIMEOUT_S > DONE_S) ? TIMEOUT_S : DONE_S;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  if (MAX_AMOUNT * SEC_PER_UNIT >= (1 << REM_W)) begin : g_rem_range
    $error("MAX_AMOUNT * SEC_PER_UNIT does not fit in remaining");
  end

  logic             w_evt;
  evt_class_e       w_evt_class;
  logic [KEY_W-1:0] w_evt_digit;

  key_event u_key_event (
    .CLK      (CLK),
    .RST      (RST),
    .kb_idle  (kb_idle),
    .kb_data  (kb_data),
    .kb_start (kb_start),
    .kb_reset (kb_reset),
    .kb_ok    (kb_ok),
    .evt      (w_evt),
    .evt_class(w_evt_class),
    .evt_digit(w_evt_digit)
  );

  logic [3:0]        r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [AMT_W-1:0]  r_amount, w_amount_nxt;
  logic [DCNT_W-1:0] r_digit_cnt, w_digit_cnt_nxt;
  logic [REM_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_err, w_err_nxt;
  logic              r_charging, r_done;
  logic [AMT_W-1:0]  w_amt_acc;
  logic [REM_W-1:0]  w_amt_sec;
  logic              w_amt_ok;

  assign w_amt_acc = AMT_W'(r_amount * AMT_W'(10)) + AMT_W'(w_evt_digit);
  assign w_amt_sec = REM_W'(r_amount) * REM_W'(SEC_PER_UNIT);
  assign w_amt_ok  = (r_amount != '0) && (r_amount <= AMT_W'(MAX_AMOUNT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_amount    <= '0;
      r_digit_cnt <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_charging  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_amount    <= w_amount_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_remaining <= w_remaining_nxt;
      r_err       <= w_err_nxt;
      r_charging  <= (w_state_nxt == ST_CHARGE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath; the shared timer is the ENTER timeout or DONE hold.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_amount_nxt    = r_amount;
    w_digit_cnt_nxt = r_digit_cnt;
    w_remaining_nxt = r_remaining;
    w_err_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_evt && (w_evt_class == EVT_START)) begin
          w_state_nxt     = ST_ENTER;
          w_tmr_nxt       = '0;
          w_amount_nxt    = '0;
          w_digit_cnt_nxt = '0;
          w_remaining_nxt = '0;
        end
      end

      ST_ENTER: begin
        if (w_evt) begin
          w_tmr_nxt = '0;
          case (w_evt_class)
            EVT_DIGIT: begin
              if (r_digit_cnt < DCNT_W'(2)) begin
                w_amount_nxt    = w_amt_acc;
                w_digit_cnt_nxt = r_digit_cnt + DCNT_W'(1);
              end
            end
            EVT_RESET: begin
              w_amount_nxt    = '0;
              w_digit_cnt_nxt = '0;
            end
            EVT_OK: begin
              if (w_amt_ok) begin
                w_remaining_nxt = w_amt_sec;
                w_state_nxt     = ST_CHARGE;
              end else begin
                w_err_nxt       = 1'b1;
                w_amount_nxt    = '0;
                w_digit_cnt_nxt = '0;
              end
            end
            default: ;
          endcase
        end else if (tick_1hz) begin
          if (r_tmr >= TMR_W'(TIMEOUT_S - 1)) begin
            w_state_nxt     = ST_IDLE;
            w_tmr_nxt       = '0;
            w_amount_nxt    = '0;
            w_digit_cnt_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
      end

      ST_CHARGE: begin
        if (w_evt && (w_evt_class == EVT_RESET)) begin
          w_state_nxt     = ST_IDLE;
          w_amount_nxt    = '0;
          w_digit_cnt_nxt = '0;
          w_remaining_nxt = '0;
        end else if (tick_1hz) begin
          if (r_remaining <= REM_W'(1)) begin
            w_remaining_nxt = '0;
            w_state_nxt     = ST_DONE;
            w_tmr_nxt       = '0;
          end else begin
            w_remaining_nxt = r_remaining - REM_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (w_evt && (w_evt_class == EVT_START)) begin
          w_state_nxt     = ST_ENTER;
          w_tmr_nxt       = '0;
          w_amount_nxt    = '0;
          w_digit_cnt_nxt = '0;
        end else if (tick_1hz) begin
          if (r_tmr >= TMR_W'(DONE_S - 1)) begin
            w_state_nxt     = ST_IDLE;
            w_tmr_nxt       = '0;
            w_amount_nxt    = '0;
            w_digit_cnt_nxt = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_tmr_nxt       = '0;
        w_amount_nxt    = '0;
        w_digit_cnt_nxt = '0;
        w_remaining_nxt = '0;
      end
    endcase
  end

  assign charging  = r_charging;
  assign done      = r_done;
  assign err       = r_err;
  assign amount    = r_amount;
  assign digit_cnt = r_digit_cnt;
  assign remaining = r_remaining;

endmodule
